pong_engine: RTL

- Parametrised two-player Pong game core: game state, ball physics, paddle clamping, scoring and pixel colour generation in one block.
- Runs on the pixel clock and advances game state once per frame, on a one-cycle frame_start strobe from the VGA timing generator.
- Adds to the earlier single-screen version: serve/point/game-over state machine, per-player scores, explicit direction setting on collisions (no toggling), paddle clamping and 2-bit-per-channel colour.

---
 rtl/pong_pkg.sv | 31 +++
 rtl/pong_renderer.sv | 60 ++++++
 rtl/pong_engine.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types, colours and hit-test helper for the pong core
package pong_pkg;

  typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} state_t;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t COLOUR_BG      = '{r: 2'd0, g: 2'd0, b: 2'd0};
  localparam rgb_t COLOUR_BALL    = '{r: 2'd3, g: 2'd3, b: 2'd3};
  localparam rgb_t COLOUR_PADDLE1 = '{r: 2'd3, g: 2'd0, b: 2'd0};
  localparam rgb_t COLOUR_PADDLE2 = '{r: 2'd0, g: 2'd0, b: 2'd3};
  localparam rgb_t COLOUR_NET     = '{r: 2'd1, g: 2'd1, b: 2'd1};

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic DIR_UP    = 1'b0;

  // Modular difference at w bits, so positions left of / above origin wrap high and miss.
  function automatic logic in_span(input logic [31:0] pos, input logic [31:0] origin,
                                   input logic [31:0] size, input int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return ((pos - origin) & mask) < size;
  endfunction

endpackage

// File: rtl/pong_renderer.sv
// rtl/pong_renderer.sv - per-pixel colour generation with one registered stage
module pong_renderer
  import pong_pkg::*;
#(
  parameter int COORD_W      = 10,
  parameter int SCREEN_W     = 640,
  parameter int BALL_SIZE    = 4,
  parameter int PADDLE_W     = 4,
  parameter int PADDLE_H     = 50,
  parameter int PADDLE1_HPOS = 10,
  parameter int PADDLE2_HPOS = 626,
  parameter int NET_W        = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic               de,
  input  logic [COORD_W-1:0] ball_hpos,
  input  logic [COORD_W-1:0] ball_vpos,
  input  logic               ball_visible,
  input  logic [COORD_W-1:0] paddle1_vpos,
  input  logic [COORD_W-1:0] paddle2_vpos,
  output logic [1:0]         r,
  output logic [1:0]         g,
  output logic [1:0]         b
);

  rgb_t pix, pix_q;
  logic on_ball, on_paddle1, on_paddle2, on_net;

  always_comb begin
    on_ball    = ball_visible
               && in_span(32'(hpos), 32'(ball_hpos), 32'(BALL_SIZE), COORD_W)
               && in_span(32'(vpos), 32'(ball_vpos), 32'(BALL_SIZE), COORD_W);
    on_paddle1 = in_span(32'(hpos), 32'(PADDLE1_HPOS), 32'(PADDLE_W), COORD_W)
               && in_span(32'(vpos), 32'(paddle1_vpos), 32'(PADDLE_H), COORD_W);
    on_paddle2 = in_span(32'(hpos), 32'(PADDLE2_HPOS), 32'(PADDLE_W), COORD_W)
               && in_span(32'(vpos), 32'(paddle2_vpos), 32'(PADDLE_H), COORD_W);
    // Dashed net: drawn on alternate 8-line bands.
    on_net     = in_span(32'(hpos), 32'(SCREEN_W / 2 - NET_W / 2), 32'(NET_W), COORD_W)
               && vpos[3];
    pix = COLOUR_BG;
    if (!de)             pix = COLOUR_BG;
    else if (on_ball)    pix = COLOUR_BALL;
    else if (on_paddle1) pix = COLOUR_PADDLE1;
    else if (on_paddle2) pix = COLOUR_PADDLE2;
    else if (on_net)     pix = COLOUR_NET;
  end

  always_ff @(posedge clk) begin
    if (reset) pix_q <= COLOUR_BG;
    else       pix_q <= pix;
  end

  assign r = pix_q.r;
  assign g = pix_q.g;
  assign b = pix_q.b;

endmodule

// File: rtl/pong_engine.sv
// rtl/pong_engine.sv - two-player pong game state, ball physics, scoring and rendering
module pong_engine
  import pong_pkg::*;
#(
  parameter int COORD_W      = 10,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 4,
  parameter int BALL_SPEED   = 4,
  parameter int PADDLE_W     = 4,
  parameter int PADDLE_H     = 50,
  parameter int PADDLE1_HPOS = 10,
  parameter int PADDLE2_HPOS = 626,
  parameter int NET_W        = 3,
  parameter int SCORE_W      = 4,
  parameter int SCORE_MAX    = 9,
  parameter int POINT_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               serve,
  input  logic [COORD_W-1:0] paddle1_next,
  input  logic [COORD_W-1:0] paddle2_next,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic               de,
  output logic [1:0]         r,
  output logic [1:0]         g,
  output logic [1:0]         b,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over
);

  localparam int CNT_W = $clog2(POINT_FRAMES + 1);
  localparam logic [COORD_W-1:0] BALL_X0      = COORD_W'(SCREEN_W / 2);
  localparam logic [COORD_W-1:0] BALL_Y0      = COORD_W'(SCREEN_H / 2);
  localparam logic [COORD_W-1:0] SPEED        = COORD_W'(BALL_SPEED);
  localparam logic [COORD_W-1:0] RIGHT_LIMIT  = COORD_W'(SCREEN_W - BALL_SIZE - BALL_SPEED);
  localparam logic [COORD_W-1:0] BOTTOM_LIMIT = COORD_W'(SCREEN_H - BALL_SIZE - BALL_SPEED);
  localparam logic [COORD_W-1:0] PADDLE_MAX   = COORD_W'(SCREEN_H - PADDLE_H);
  localparam logic [COORD_W-1:0] PADDLE_Y0    = COORD_W'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [SCORE_W-1:0] SCORE_TOP    = SCORE_W'(SCORE_MAX);
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(POINT_FRAMES - 1);

  state_t             state, state_next;
  logic [COORD_W-1:0] ball_hpos, ball_vpos, ball_hpos_next, ball_vpos_next;
  logic [COORD_W-1:0] paddle1_vpos, paddle2_vpos;
  logic               h_dir, v_dir, h_dir_next, v_dir_next;
  logic [SCORE_W-1:0] score1_next, score2_next;
  logic [CNT_W-1:0]   point_cnt, point_cnt_next;
  logic               hit1, hit2, ball_visible;

  // Interval overlap of the ball with a span, expressed as a widened single hit-test.
  function automatic logic overlaps(input logic [COORD_W-1:0] ball,
                                    input logic [COORD_W-1:0] origin, input int len);
    return in_span(32'(ball), 32'(origin) - 32'(BALL_SIZE - 1),
                   32'(len + BALL_SIZE - 1), COORD_W);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_TOP) ? s : s + 1'b1;
  endfunction

  always_comb begin
    hit1 = overlaps(ball_hpos, COORD_W'(PADDLE1_HPOS), PADDLE_W)
        && overlaps(ball_vpos, paddle1_vpos, PADDLE_H);
    hit2 = overlaps(ball_hpos, COORD_W'(PADDLE2_HPOS), PADDLE_W)
        && overlaps(ball_vpos, paddle2_vpos, PADDLE_H);
  end

  always_comb begin
    state_next     = state;
    ball_hpos_next = ball_hpos;
    ball_vpos_next = ball_vpos;
    h_dir_next     = h_dir;
    v_dir_next     = v_dir;
    score1_next    = score1;
    score2_next    = score2;
    point_cnt_next = point_cnt;
    case (state)
      SERVE: begin
        ball_hpos_next = BALL_X0;
        ball_vpos_next = BALL_Y0;
        if (serve) state_next = PLAY;
      end
      PLAY: begin
        if (hit1)      h_dir_next = DIR_RIGHT;
        else if (hit2) h_dir_next = DIR_LEFT;
        if (ball_vpos < SPEED && v_dir == DIR_UP)                v_dir_next = DIR_DOWN;
        else if (ball_vpos >= BOTTOM_LIMIT && v_dir == DIR_DOWN) v_dir_next = DIR_UP;
        // h_dir already points at the conceding side, so it is kept through POINT.
        if (!hit1 && !hit2 && h_dir == DIR_LEFT && ball_hpos < SPEED) begin
          score2_next    = sat_inc(score2);
          point_cnt_next = '0;
          state_next     = POINT;
        end else if (!hit1 && !hit2 && h_dir == DIR_RIGHT && ball_hpos >= RIGHT_LIMIT) begin
          score1_next    = sat_inc(score1);
          point_cnt_next = '0;
          state_next     = POINT;
        end else begin
          ball_hpos_next = (h_dir_next == DIR_RIGHT) ? ball_hpos + SPEED : ball_hpos - SPEED;
          ball_vpos_next = (v_dir_next == DIR_DOWN)  ? ball_vpos + SPEED : ball_vpos - SPEED;
        end
      end
      POINT: begin
        if (point_cnt == CNT_LAST) begin
          ball_hpos_next = BALL_X0;
          ball_vpos_next = BALL_Y0;
          state_next     = (score1 == SCORE_TOP || score2 == SCORE_TOP) ? OVER : SERVE;
        end else begin
          point_cnt_next = point_cnt + 1'b1;
        end
      end
      OVER: begin
        if (serve) begin
          score1_next = '0;
          score2_next = '0;
          state_next  = SERVE;
        end
      end
      default: state_next = SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SERVE;
      ball_hpos    <= BALL_X0;
      ball_vpos    <= BALL_Y0;
      h_dir        <= DIR_RIGHT;
      v_dir        <= DIR_DOWN;
      score1       <= '0;
      score2       <= '0;
      point_cnt    <= '0;
      paddle1_vpos <= PADDLE_Y0;
      paddle2_vpos <= PADDLE_Y0;
    end else if (frame_start) begin
      state        <= state_next;
      ball_hpos    <= ball_hpos_next;
      ball_vpos    <= ball_vpos_next;
      h_dir        <= h_dir_next;
      v_dir        <= v_dir_next;
      score1       <= score1_next;
      score2       <= score2_next;
      point_cnt    <= point_cnt_next;
      paddle1_vpos <= (paddle1_next > PADDLE_MAX) ? PADDLE_MAX : paddle1_next;
      paddle2_vpos <= (paddle2_next > PADDLE_MAX) ? PADDLE_MAX : paddle2_next;
    end
  end

  assign game_over    = (state == OVER);
  assign ball_visible = (state == SERVE) || (state == PLAY);

  pong_renderer #(
    .COORD_W(COORD_W), .SCREEN_W(SCREEN_W), .BALL_SIZE(BALL_SIZE),
    .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H), .PADDLE1_HPOS(PADDLE1_HPOS),
    .PADDLE2_HPOS(PADDLE2_HPOS), .NET_W(NET_W)
  ) u_renderer (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .de(de),
    .ball_hpos(ball_hpos), .ball_vpos(ball_vpos), .ball_visible(ball_visible),
    .paddle1_vpos(paddle1_vpos), .paddle2_vpos(paddle2_vpos),
    .r(r), .g(g), .b(b)
  );

endmodule
